// File: rtl/router_pkg.sv
// Shared constants and types for the router datapath register stage.
package router_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 2;

    // Header layout: {length, addr}
    localparam int ADDR_LSB = 0;
    localparam int LEN_LSB  = 2;

    // Destination 3 has no output FIFO, so a header that targets it is never captured.
    localparam logic [ADDR_WIDTH-1:0] INVALID_ADDR = {ADDR_WIDTH{1'b1}};

    // Encoding of the router control FSM that drives the state strobes.
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_e;

    // True when a header byte addresses one of the real output FIFOs.
    function automatic logic addr_is_valid(input logic [DATA_WIDTH-1:0] hdr);
        return hdr[ADDR_LSB +: ADDR_WIDTH] != INVALID_ADDR;
    endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR parity over header and payload, capture of the trailing parity
// byte, and the sticky mismatch flag.
module router_parity_chk
    import router_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  detect_add_i,
    input  logic                  lfd_state_i,
    input  logic                  ld_state_i,
    input  logic                  laf_state_i,
    input  logic                  full_state_i,
    input  logic                  pkt_valid_i,
    input  logic                  fifo_full_i,
    input  logic                  low_pkt_valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0] header_byte_i,
    input  logic [DATA_WIDTH-1:0] full_byte_i,
    output logic                  parity_done_o,
    output logic                  err_o
);

    logic [DATA_WIDTH-1:0] internal_parity_q, internal_parity_d;
    logic [DATA_WIDTH-1:0] packet_parity_q, packet_parity_d;
    logic                  parity_done_q, parity_done_d;
    logic                  err_q, err_d;

    // Next-state for the parity accumulator, captured parity byte and error flag.
    always_comb begin
        internal_parity_d = internal_parity_q;
        packet_parity_d   = packet_parity_q;
        parity_done_d     = parity_done_q;
        err_d             = err_q;

        // A byte parked in full_byte was already folded in while in LOAD_DATA,
        // so LOAD_AFTER_FULL never touches the accumulator.
        if (detect_add_i) begin
            internal_parity_d = '0;
        end else if (lfd_state_i) begin
            internal_parity_d = internal_parity_q ^ header_byte_i;
        end else if (ld_state_i && pkt_valid_i && !full_state_i) begin
            internal_parity_d = internal_parity_q ^ data_i;
        end

        // The parity byte arrives either directly, or via full_byte when the
        // FIFO was full in the parity cycle.
        if (detect_add_i) begin
            packet_parity_d = '0;
            parity_done_d   = 1'b0;
        end else if (ld_state_i && !pkt_valid_i && !fifo_full_i) begin
            packet_parity_d = data_i;
            parity_done_d   = 1'b1;
        end else if (laf_state_i && low_pkt_valid_i && !parity_done_q) begin
            packet_parity_d = full_byte_i;
            parity_done_d   = 1'b1;
        end

        // Compare uses registered values, so err trails parity_done by a cycle.
        if (detect_add_i) begin
            err_d = 1'b0;
        end else if (parity_done_q && (internal_parity_q != packet_parity_q)) begin
            err_d = 1'b1;
        end
    end

    // Parity state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            internal_parity_q <= '0;
            packet_parity_q   <= '0;
            parity_done_q     <= 1'b0;
            err_q             <= 1'b0;
        end else begin
            internal_parity_q <= internal_parity_d;
            packet_parity_q   <= packet_parity_d;
            parity_done_q     <= parity_done_d;
            err_q             <= err_d;
        end
    end

    assign parity_done_o = parity_done_q;
    assign err_o         = err_q;

endmodule

// File: rtl/router_reg.sv
// Datapath register stage behind the router control FSM: header capture,
// full-FIFO byte parking, output byte register and low_pkt_valid flag.
module router_reg
    import router_pkg::*;
(
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  rst_int_reg,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] header_byte_q, header_byte_d;
    logic [DATA_WIDTH-1:0] full_byte_q, full_byte_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  low_pkt_valid_q, low_pkt_valid_d;

    // Next-state for header, parked byte, output byte and low_pkt_valid.
    always_comb begin
        header_byte_d   = header_byte_q;
        full_byte_d     = full_byte_q;
        dout_d          = dout_q;
        low_pkt_valid_d = low_pkt_valid_q;

        if (detect_add && pkt_valid && addr_is_valid(data_in)) begin
            header_byte_d = data_in;
        end

        // When the FIFO is full in LOAD_DATA the byte is parked and replayed
        // from full_byte in LOAD_AFTER_FULL.
        if (lfd_state) begin
            dout_d = header_byte_q;
        end else if (ld_state && !fifo_full) begin
            dout_d = data_in;
        end else if (ld_state && fifo_full) begin
            full_byte_d = data_in;
        end else if (laf_state) begin
            dout_d = full_byte_q;
        end

        // The FSM's clear takes priority over a simultaneous set.
        if (rst_int_reg) begin
            low_pkt_valid_d = 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header_byte_q   <= '0;
            full_byte_q     <= '0;
            dout_q          <= '0;
            low_pkt_valid_q <= 1'b0;
        end else begin
            header_byte_q   <= header_byte_d;
            full_byte_q     <= full_byte_d;
            dout_q          <= dout_d;
            low_pkt_valid_q <= low_pkt_valid_d;
        end
    end

    router_parity_chk u_parity_chk (
        .clk_i           (clock),
        .rst_ni          (resetn),
        .detect_add_i    (detect_add),
        .lfd_state_i     (lfd_state),
        .ld_state_i      (ld_state),
        .laf_state_i     (laf_state),
        .full_state_i    (full_state),
        .pkt_valid_i     (pkt_valid),
        .fifo_full_i     (fifo_full),
        .low_pkt_valid_i (low_pkt_valid_q),
        .data_i          (data_in),
        .header_byte_i   (header_byte_q),
        .full_byte_i     (full_byte_q),
        .parity_done_o   (parity_done),
        .err_o           (err)
    );

    assign dout          = dout_q;
    assign low_pkt_valid = low_pkt_valid_q;

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: good/bad packets, full stalls, invalid
// address, and asynchronous reset mid-packet.
module tb_router_reg;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       fifo_full = 1'b0;
    logic       rst_int_reg = 1'b0;
    logic       detect_add = 1'b0;
    logic       lfd_state = 1'b0;
    logic       ld_state = 1'b0;
    logic       laf_state = 1'b0;
    logic       full_state = 1'b0;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;
    logic [7:0] dout;

    int tests_run = 0;
    int tests_failed = 0;

    router_reg dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .rst_int_reg   (rst_int_reg),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err),
        .dout          (dout)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle: strobe selector st = {da, lfd, ld, laf, fs}, then sample 1 time unit after the edge.
    task automatic cyc(input logic [4:0] st, input logic pv, input logic ff,
                       input logic ri, input logic [7:0] d);
        {detect_add, lfd_state, ld_state, laf_state, full_state} = st;
        pkt_valid   = pv;
        fifo_full   = ff;
        rst_int_reg = ri;
        data_in     = d;
        @(posedge clock);
        #1;
    endtask

    localparam logic [4:0] S_DA   = 5'b10000;
    localparam logic [4:0] S_LFD  = 5'b01000;
    localparam logic [4:0] S_LD   = 5'b00100;
    localparam logic [4:0] S_LAF  = 5'b00010;
    localparam logic [4:0] S_FS   = 5'b00001;
    localparam logic [4:0] S_IDLE = 5'b00000;

    initial begin
        // Reset state
        #2;
        check("rst_dout", dout, 8'h00);
        check("rst_pd", {7'b0, parity_done}, 8'h00);
        check("rst_lpv", {7'b0, low_pkt_valid}, 8'h00);
        check("rst_err", {7'b0, err}, 8'h00);
        #10 resetn = 1'b1;
        @(posedge clock); #1;

        // Good packet: 09, A5, 3C, parity 90
        cyc(S_DA, 1, 0, 0, 8'h09);
        cyc(S_LFD, 1, 0, 0, 8'hA5);
        check("good_hdr", dout, 8'h09);
        cyc(S_LD, 1, 0, 0, 8'hA5);
        check("good_p0", dout, 8'hA5);
        cyc(S_LD, 1, 0, 0, 8'h3C);
        check("good_p1", dout, 8'h3C);
        cyc(S_LD, 0, 0, 0, 8'h90);
        check("good_par", dout, 8'h90);
        check("good_pd", {7'b0, parity_done}, 8'h01);
        check("good_lpv", {7'b0, low_pkt_valid}, 8'h01);
        cyc(S_IDLE, 0, 0, 1, 8'h00);
        check("good_err", {7'b0, err}, 8'h00);
        check("good_lpv_clr", {7'b0, low_pkt_valid}, 8'h00);

        // Bad parity: 91 instead of 90
        cyc(S_DA, 1, 0, 0, 8'h09);
        check("bad_pd_clr", {7'b0, parity_done}, 8'h00);
        cyc(S_LFD, 1, 0, 0, 8'hA5);
        cyc(S_LD, 1, 0, 0, 8'hA5);
        cyc(S_LD, 1, 0, 0, 8'h3C);
        cyc(S_LD, 0, 0, 0, 8'h91);
        check("bad_pd", {7'b0, parity_done}, 8'h01);
        check("bad_err_early", {7'b0, err}, 8'h00);
        cyc(S_IDLE, 0, 0, 1, 8'h00);
        check("bad_err", {7'b0, err}, 8'h01);
        cyc(S_IDLE, 0, 0, 0, 8'h00);
        check("bad_err_sticky", {7'b0, err}, 8'h01);
        cyc(S_DA, 1, 0, 0, 8'h09);
        check("bad_err_clr", {7'b0, err}, 8'h00);

        // Invalid address: header 07 must not be captured
        cyc(S_DA, 1, 0, 0, 8'h07);
        cyc(S_LFD, 1, 0, 0, 8'h00);
        check("inv_hdr", dout, 8'h09);

        // FIFO full on a payload byte
        cyc(S_DA, 1, 0, 0, 8'h09);
        cyc(S_LFD, 1, 1, 0, 8'hA5);
        check("ff_hdr", dout, 8'h09);
        cyc(S_LD, 1, 0, 0, 8'hA5);
        cyc(S_LD, 1, 1, 0, 8'h3C);
        check("ff_hold", dout, 8'hA5);
        cyc(S_FS, 1, 1, 0, 8'h3C);
        check("ff_fs_hold", dout, 8'hA5);
        cyc(S_LAF, 1, 0, 0, 8'h3C);
        check("ff_laf", dout, 8'h3C);
        cyc(S_LD, 0, 0, 0, 8'h90);
        check("ff_par", dout, 8'h90);
        check("ff_pd", {7'b0, parity_done}, 8'h01);
        cyc(S_IDLE, 0, 0, 1, 8'h00);
        check("ff_err", {7'b0, err}, 8'h00);

        // FIFO full on the parity byte
        cyc(S_DA, 1, 0, 0, 8'h09);
        cyc(S_LFD, 1, 0, 0, 8'hA5);
        cyc(S_LD, 1, 0, 0, 8'hA5);
        cyc(S_LD, 1, 0, 0, 8'h3C);
        cyc(S_LD, 0, 1, 0, 8'h90);
        check("fp_hold", dout, 8'h3C);
        check("fp_lpv", {7'b0, low_pkt_valid}, 8'h01);
        check("fp_pd_wait", {7'b0, parity_done}, 8'h00);
        cyc(S_FS, 0, 1, 0, 8'h00);
        cyc(S_LAF, 0, 0, 0, 8'h00);
        check("fp_laf", dout, 8'h90);
        check("fp_pd", {7'b0, parity_done}, 8'h01);
        cyc(S_IDLE, 0, 0, 0, 8'h00);
        check("fp_err", {7'b0, err}, 8'h00);
        check("fp_lpv_hold", {7'b0, low_pkt_valid}, 8'h01);
        cyc(S_IDLE, 0, 0, 1, 8'h00);
        check("fp_lpv_clr", {7'b0, low_pkt_valid}, 8'h00);

        // Clear wins over set for low_pkt_valid
        cyc(S_LD, 0, 0, 1, 8'h00);
        check("lpv_clr_wins", {7'b0, low_pkt_valid}, 8'h00);

        // Reset mid-packet after a bad packet left err/pd/lpv set
        cyc(S_DA, 1, 0, 0, 8'h09);
        cyc(S_LFD, 1, 0, 0, 8'hA5);
        cyc(S_LD, 1, 0, 0, 8'hA5);
        cyc(S_LD, 1, 0, 0, 8'h3C);
        cyc(S_LD, 0, 0, 0, 8'h91);
        cyc(S_IDLE, 0, 0, 0, 8'h00);
        check("pre_rst_err", {7'b0, err}, 8'h01);
        {detect_add, lfd_state, ld_state, laf_state, full_state} = S_LD;
        pkt_valid = 1'b1;
        data_in   = 8'hA5;
        #2 resetn = 1'b0;
        #1;
        check("arst_dout", dout, 8'h00);
        check("arst_err", {7'b0, err}, 8'h00);
        check("arst_pd", {7'b0, parity_done}, 8'h00);
        check("arst_lpv", {7'b0, low_pkt_valid}, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        // Good packet after reset
        cyc(S_DA, 1, 0, 0, 8'h09);
        cyc(S_LFD, 1, 0, 0, 8'hA5);
        check("post_hdr", dout, 8'h09);
        cyc(S_LD, 1, 0, 0, 8'hA5);
        cyc(S_LD, 1, 0, 0, 8'h3C);
        cyc(S_LD, 0, 0, 0, 8'h90);
        check("post_pd", {7'b0, parity_done}, 8'h01);
        cyc(S_IDLE, 0, 0, 1, 8'h00);
        check("post_err", {7'b0, err}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage directly downstream of the router control FSM.
- Consumes the FSM state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) and the incoming byte stream.
- Produces the byte written into the selected output FIFO (dout), plus the low_pkt_valid and parity_done handshakes fed back to the FSM.
- Computes running XOR parity over header and payload and flags a mismatch against the trailing parity byte (err).

Parameters:
DATA_WIDTH, 8, byte width of data_in/dout and all parity registers
ADDR_WIDTH, 2, width of header destination field, header bits [ADDR_WIDTH-1:0]

Ports:
clock  in  1  system clock, all state updates on rising edge
resetn  in  1  asynchronous active-low reset
pkt_valid  in  1  high while header/payload bytes are on data_in; low in the parity-byte cycle
data_in  in  DATA_WIDTH  incoming byte: header = {length[7:2], addr[1:0]}, then payload, then parity
fifo_full  in  1  selected output FIFO full
rst_int_reg  in  1  FSM strobe, clears low_pkt_valid
detect_add  in  1  FSM in DECODE_ADDRESS
lfd_state  in  1  FSM in LOAD_FIRST_DATA
ld_state  in  1  FSM in LOAD_DATA
laf_state  in  1  FSM in LOAD_AFTER_FULL
full_state  in  1  FSM in FIFO_FULL_STATE
parity_done  out  1  parity byte captured for the current packet
low_pkt_valid  out  1  pkt_valid fell while in LOAD_DATA
err  out  1  packet parity mismatch, sticky until next detect_add
dout  out  DATA_WIDTH  registered byte to FIFO write port

Behaviour:
- Reset (resetn=0, async): dout, header_byte, full_byte, internal_parity, packet_parity = 0; parity_done, low_pkt_valid, err = 0.
- All other updates are synchronous. State strobes are one-hot; behaviour with more than one strobe asserted is undefined.
- header_byte: loads data_in when detect_add && pkt_valid && data_in[1:0] != 2'b11. Otherwise holds. Addr 3 is never captured.
- dout, priority order:
  - lfd_state -> header_byte.
  - ld_state && !fifo_full -> data_in.
  - ld_state && fifo_full -> full_byte <= data_in; dout holds.
  - laf_state -> full_byte.
  - Else hold.
  - Latency: a data_in byte appears on dout 1 cycle later; the header appears 1 cycle after lfd_state.
- internal_parity:
  - detect_add -> 0.
  - lfd_state -> ^= header_byte.
  - ld_state && pkt_valid && !full_state -> ^= data_in.
  - The parity byte itself (pkt_valid=0) is never accumulated.
  - A byte diverted into full_byte is accumulated exactly once, in LOAD_DATA, and not again in laf_state.
- packet_parity:
  - detect_add -> 0.
  - ld_state && !pkt_valid && !fifo_full -> data_in.
  - laf_state && low_pkt_valid && !parity_done -> full_byte (the parity byte was parked there on full).
- parity_done: cleared on detect_add. Set on the same two conditions that load packet_parity. Holds otherwise; set at most once per packet.
- low_pkt_valid: set on ld_state && !pkt_valid. Cleared on rst_int_reg, and the clear wins if both occur in the same cycle. Holds otherwise.
- err:
  - detect_add -> 0.
  - Else if parity_done && internal_parity != packet_parity -> 1.
  - Asserts 1 cycle after parity_done rises; sticky until the next detect_add.
- Boundaries:
  - fifo_full during header or lfd_state: no effect. The FSM only stalls from LOAD_DATA.
  - Back-to-back packets: detect_add clears all per-packet state before the next lfd_state.
  - Async reset mid-packet: everything clears immediately, and no stale err or parity_done is seen afterwards.
  - Soft reset handled by the FSM returning to DECODE_ADDRESS: detect_add then clears per-packet state.

Decomposition:
- Shared package router_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH.
  - INVALID_ADDR = 2'b11.
  - Header field slice constants (ADDR_LSB=0, LEN_LSB=2).
  - The FSM state encoding.
- One natural sub-module: router_parity_chk. It holds internal_parity, packet_parity, parity_done and err. Its inputs are the strobes, data_in, header_byte and full_byte. router_reg keeps header_byte, full_byte, dout and low_pkt_valid.

Test Plan:
- Good packet:
  - Stimulus: header 8'h09 (len 2, addr 1), payload 8'hA5, 8'h3C, parity 8'h90, no full.
  - Expect: dout sequence 09, A5, 3C, 90; parity_done=1 after the parity cycle; err stays 0.
- Bad parity:
  - Stimulus: same packet with parity 8'h91.
  - Expect: err=1 one cycle after parity_done; err cleared on the next detect_add.
- FIFO full on payload:
  - Stimulus: fifo_full=1 during ld_state with data_in=8'h3C.
  - Expect: dout holds A5 and full_byte=3C; in laf_state dout=3C; internal_parity ends at 8'h90.
- Full on parity byte:
  - Stimulus: fifo_full=1 with pkt_valid=0 in ld_state, data_in=8'h90.
  - Expect: low_pkt_valid=1. In laf_state: packet_parity=8'h90, parity_done=1, err=0. Then rst_int_reg clears low_pkt_valid.
- Invalid address:
  - Stimulus: detect_add && pkt_valid with data_in=8'h07.
  - Expect: header_byte unchanged (holds previous value 8'h09).
- Reset mid-packet:
  - Stimulus: resetn=0 during ld_state, asynchronous to clock.
  - Expect: dout=0, err=0, parity_done=0, low_pkt_valid=0 immediately. A following good packet completes with err=0.
